// File: rtl/par_gen_chk.sv
// par_gen_chk: UART parity unit.
//   TX side: registers the parity bit of P_DATA when a word is accepted.
//   RX side: accumulates parity over a serial bit stream and checks the
//   received parity bit, pulsing RX_CHK_DONE / RX_PAR_ERR at frame end.
//   A saturating counter tracks parity errors.
// Ports:
//   CLK, RST                  clock (rising edge), async active-low reset
//   P_DATA, Data_Valid, Busy  TX word, valid, serializer busy
//   PAR_EN, PAR_MODE          parity enable, mode (00 even, 01 odd, 10 mark, 11 space)
//   Par_Bit                   registered TX parity bit
//   RX_START                  start-bit detect, (re)arms the checker
//   RX_BIT_VALID, RX_BIT      sampled RX bit strobe and value, LSB first
//   RX_CHK_DONE, RX_PAR_ERR   one-cycle frame-complete / parity-error pulses
//   ERR_CNT, ERR_CNT_CLR      saturating error count and its synchronous clear
module par_gen_chk #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    P_DATA,
    input  logic                     Data_Valid,
    input  logic                     Busy,
    input  logic                     PAR_EN,
    input  logic [1:0]               PAR_MODE,
    output logic                     Par_Bit,
    input  logic                     RX_START,
    input  logic                     RX_BIT_VALID,
    input  logic                     RX_BIT,
    output logic                     RX_CHK_DONE,
    output logic                     RX_PAR_ERR,
    output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
    input  logic                     ERR_CNT_CLR
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } rx_state_t;

    // TX parity of the presented word under the current mode
    logic tx_par;
    always_comb begin
        case (PAR_MODE)
            2'b00:   tx_par = ^P_DATA;
            2'b01:   tx_par = ~^P_DATA;
            2'b10:   tx_par = 1'b1;
            default: tx_par = 1'b0;
        endcase
    end

    // TX parity register: captures only on an accepted word with parity on
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Par_Bit <= 1'b0;
        end else if (Data_Valid && !Busy && PAR_EN) begin
            Par_Bit <= tx_par;
        end
    end

    rx_state_t        state, state_nxt;
    logic             acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic             en_q, en_nxt;
    logic             done_nxt, err_nxt;
    logic             rx_exp;

    // Expected RX parity bit, from the mode latched at frame start
    always_comb begin
        case (mode_q)
            2'b00:   rx_exp = acc;
            2'b01:   rx_exp = ~acc;
            2'b10:   rx_exp = 1'b1;
            default: rx_exp = 1'b0;
        endcase
    end

    // RX checker next-state and pulse outputs; RX_START overrides everything
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        en_nxt    = en_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (RX_START) begin
            acc_nxt   = 1'b0;
            cnt_nxt   = '0;
            mode_nxt  = PAR_MODE;
            en_nxt    = PAR_EN;
            state_nxt = DATA;
        end else begin
            case (state)
                DATA: begin
                    if (RX_BIT_VALID) begin
                        acc_nxt = acc ^ RX_BIT;
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == LAST_BIT) begin
                            if (en_q) begin
                                state_nxt = PAR;
                            end else begin
                                done_nxt  = 1'b1;
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
                PAR: begin
                    if (RX_BIT_VALID) begin
                        done_nxt  = 1'b1;
                        err_nxt   = (RX_BIT != rx_exp);
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // RX checker state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            acc         <= 1'b0;
            cnt         <= '0;
            mode_q      <= 2'b00;
            en_q        <= 1'b0;
            RX_CHK_DONE <= 1'b0;
            RX_PAR_ERR  <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            mode_q      <= mode_nxt;
            en_q        <= en_nxt;
            RX_CHK_DONE <= done_nxt;
            RX_PAR_ERR  <= err_nxt;
        end
    end

    // Saturating error counter; clear beats a coincident error pulse
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ERR_CNT <= '0;
        end else if (ERR_CNT_CLR) begin
            ERR_CNT <= '0;
        end else if (RX_PAR_ERR && (ERR_CNT != '1)) begin
            ERR_CNT <= ERR_CNT + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_par_gen_chk.sv
// tb_par_gen_chk: directed self-checking bench for par_gen_chk
// (DATA_WIDTH=8, ERR_CNT_WIDTH=2 so saturation is reachable quickly).
module tb_par_gen_chk;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Busy;
    logic       PAR_EN;
    logic [1:0] PAR_MODE;
    logic       Par_Bit;
    logic       RX_START;
    logic       RX_BIT_VALID;
    logic       RX_BIT;
    logic       RX_CHK_DONE;
    logic       RX_PAR_ERR;
    logic [1:0] ERR_CNT;
    logic       ERR_CNT_CLR;

    int n_checks = 0;
    int n_fail   = 0;

    par_gen_chk #(
        .DATA_WIDTH   (8),
        .ERR_CNT_WIDTH(2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Busy        (Busy),
        .PAR_EN      (PAR_EN),
        .PAR_MODE    (PAR_MODE),
        .Par_Bit     (Par_Bit),
        .RX_START    (RX_START),
        .RX_BIT_VALID(RX_BIT_VALID),
        .RX_BIT      (RX_BIT),
        .RX_CHK_DONE (RX_CHK_DONE),
        .RX_PAR_ERR  (RX_PAR_ERR),
        .ERR_CNT     (ERR_CNT),
        .ERR_CNT_CLR (ERR_CNT_CLR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RX_BIT_VALID = 1'b1;
        RX_BIT       = b;
        tick();
        RX_BIT_VALID = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic p, input logic with_par);
        RX_START = 1'b1;
        tick();
        RX_START = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (with_par) send_bit(p);
    endtask

    task automatic tx_word(input logic [7:0] d, input logic [1:0] m);
        P_DATA   = d;
        PAR_MODE = m;
        tick();
    endtask

    initial begin
        RST = 1'b0; P_DATA = '0; Data_Valid = 1'b0; Busy = 1'b0; PAR_EN = 1'b0;
        PAR_MODE = 2'b00; RX_START = 1'b0; RX_BIT_VALID = 1'b0; RX_BIT = 1'b0;
        ERR_CNT_CLR = 1'b0;
        tick();
        tick();
        check("rst_par_bit", 32'(Par_Bit), 32'd0);
        check("rst_done", 32'(RX_CHK_DONE), 32'd0);
        check("rst_err", 32'(RX_PAR_ERR), 32'd0);
        check("rst_errcnt", 32'(ERR_CNT), 32'd0);
        RST = 1'b1;
        tick();

        // TX generation, 8'hA5 has four ones
        PAR_EN = 1'b1; Data_Valid = 1'b1; Busy = 1'b0;
        tx_word(8'hA5, 2'b00); check("tx_even", 32'(Par_Bit), 32'd0);
        tx_word(8'hA5, 2'b01); check("tx_odd", 32'(Par_Bit), 32'd1);
        tx_word(8'hA5, 2'b11); check("tx_space", 32'(Par_Bit), 32'd0);
        tx_word(8'hA5, 2'b10); check("tx_mark", 32'(Par_Bit), 32'd1);

        // TX hold: a capture here would produce 0
        Busy = 1'b1;
        tx_word(8'h01, 2'b11); check("tx_hold_busy", 32'(Par_Bit), 32'd1);
        Busy = 1'b0; PAR_EN = 1'b0;
        tx_word(8'h01, 2'b11); check("tx_hold_paren", 32'(Par_Bit), 32'd1);
        PAR_EN = 1'b1; Data_Valid = 1'b0;
        tx_word(8'h01, 2'b11); check("tx_hold_novalid", 32'(Par_Bit), 32'd1);

        // RX good frame: 8'h07 has three ones, even parity bit is 1
        PAR_MODE = 2'b00;
        rx_frame(8'h07, 1'b1, 1'b1);
        check("rx_good_done", 32'(RX_CHK_DONE), 32'd1);
        check("rx_good_err", 32'(RX_PAR_ERR), 32'd0);
        tick();
        check("rx_good_done_end", 32'(RX_CHK_DONE), 32'd0);
        check("rx_good_errcnt", 32'(ERR_CNT), 32'd0);

        // RX bad frames and saturation of the 2-bit counter
        for (int f = 0; f < 4; f++) begin
            rx_frame(8'h07, 1'b0, 1'b1);
            check("rx_bad_done", 32'(RX_CHK_DONE), 32'd1);
            check("rx_bad_err", 32'(RX_PAR_ERR), 32'd1);
            tick();
            check("rx_bad_err_end", 32'(RX_PAR_ERR), 32'd0);
            check("rx_bad_errcnt", 32'(ERR_CNT), (f < 3) ? 32'(f + 1) : 32'd3);
        end
        // Clear coincident with an error pulse
        rx_frame(8'h07, 1'b0, 1'b1);
        check("clr_pulse_err", 32'(RX_PAR_ERR), 32'd1);
        ERR_CNT_CLR = 1'b1;
        tick();
        ERR_CNT_CLR = 1'b0;
        check("clr_errcnt", 32'(ERR_CNT), 32'd0);

        // Abort after 4 bits; restart with a coincident strobe that must be ignored
        PAR_MODE = 2'b01;
        RX_START = 1'b1;
        tick();
        RX_START = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("abort_no_done", 32'(RX_CHK_DONE), 32'd0);
        RX_START = 1'b1; RX_BIT_VALID = 1'b1; RX_BIT = 1'b1;
        tick();
        RX_START = 1'b0; RX_BIT_VALID = 1'b0;
        check("restart_no_done", 32'(RX_CHK_DONE), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0);
            if (i == 3) PAR_MODE = 2'b00;
        end
        check("odd_no_early_done", 32'(RX_CHK_DONE), 32'd0);
        send_bit(1'b1);
        check("odd_done", 32'(RX_CHK_DONE), 32'd1);
        check("odd_err", 32'(RX_PAR_ERR), 32'd0);
        tick();
        check("odd_done_end", 32'(RX_CHK_DONE), 32'd0);
        check("odd_errcnt", 32'(ERR_CNT), 32'd0);

        // Parity disabled: done right after the 8th data strobe
        PAR_EN = 1'b0; PAR_MODE = 2'b00;
        RX_START = 1'b1;
        tick();
        RX_START = 1'b0;
        PAR_EN = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check("nopar_not_yet", 32'(RX_CHK_DONE), 32'd0);
        send_bit(1'b1);
        check("nopar_done", 32'(RX_CHK_DONE), 32'd1);
        check("nopar_err", 32'(RX_PAR_ERR), 32'd0);
        tick();
        check("nopar_done_end", 32'(RX_CHK_DONE), 32'd0);

        // Reset mid-frame with nonzero state everywhere
        rx_frame(8'h07, 1'b0, 1'b1);
        tick();
        check("pre_rst_errcnt", 32'(ERR_CNT), 32'd1);
        RX_START = 1'b1;
        tick();
        RX_START = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #2 RST = 1'b0;
        #1;
        check("midrst_par_bit", 32'(Par_Bit), 32'd0);
        check("midrst_done", 32'(RX_CHK_DONE), 32'd0);
        check("midrst_err", 32'(RX_PAR_ERR), 32'd0);
        check("midrst_errcnt", 32'(ERR_CNT), 32'd0);
        tick();
        RST = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b1);
            check("idle_ignored", 32'(RX_CHK_DONE), 32'd0);
        end
        tick();
        check("idle_ignored_last", 32'(RX_CHK_DONE), 32'd0);
        rx_frame(8'h07, 1'b1, 1'b1);
        check("post_rst_done", 32'(RX_CHK_DONE), 32'd1);
        check("post_rst_err", 32'(RX_PAR_ERR), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
